// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Memory-side responder for the core's data access port. Accepts
//            one load/store at a time, waits a configurable number of cycles,
//            commits the access to a byte-enabled word array and returns the
//            result over a valid/ready response channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1       clock
//   rst         in   1       synchronous active-high reset
//   req_valid   in   1       request present
//   req_ready   out  1       responder can accept a request (IDLE only)
//   req_we      in   1       1 = store, 0 = load
//   req_addr    in   ADDR_W  byte address, word index = req_addr[ADDR_W-1:2]
//   req_wdata   in   32      store data
//   req_wstrb   in   4       byte-lane write enables
//   resp_valid  out  1       response present
//   resp_ready  in   1       requester accepts response
//   resp_rdata  out  32      load data (0 for stores / errors)
//   resp_err    out  1       access rejected
// Configuration macro
//   MEM_MISALIGN_CHECK_EN : when defined, req_addr[1:0] != 0 is an error.
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int         IDX_W     = ADDR_W - 2;
  localparam int         MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [3:0]          wait_cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [31:0]         resp_rdata_q;
  logic                resp_err_q;

  // Word array; intentionally not cleared by reset.
  logic [31:0]         mem_q [DEPTH];

  logic [IDX_W-1:0]    w_word_idx;
  logic [MEM_AW-1:0]   w_mem_idx;
  logic                w_oob;
  logic                w_misalign;
  logic                w_err;
  logic                w_commit;
  logic                w_do_write;

  assign w_word_idx = addr_q[ADDR_W-1:2];
  assign w_mem_idx  = w_word_idx[MEM_AW-1:0];
  assign w_oob      = 32'(w_word_idx) >= 32'(DEPTH);

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = (addr_q[1:0] != 2'b00);
`else
  // Byte offset is irrelevant when alignment is not enforced.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^addr_q[1:0];
  assign w_misalign        = 1'b0;
`endif

  assign w_err      = w_misalign | w_oob;
  // The access takes effect only on the last BUSY cycle; a reset on that
  // edge wins and drops the access.
  assign w_commit   = (state_q == S_BUSY) && (wait_cnt_q == WAIT_LAST);
  assign w_do_write = w_commit && we_q && !w_err && !rst;

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem_q[w_mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake outputs. The response data is
  // captured on the commit edge and resp_valid rises one edge later, so the
  // data is already stable when the requester first sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            wait_cnt_q  <= 4'd0;
            req_ready_q <= 1'b0;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_commit) begin
            resp_err_q   <= w_err;
            resp_rdata_q <= (we_q || w_err) ? 32'd0 : mem_q[w_mem_idx];
            wait_cnt_q   <= 4'd0;
            state_q      <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
          end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed self-checking bench for data_mem_responder with a
//            response scoreboard (DEPTH=1000, ADDR_W=12, WAIT_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int DEPTH = 1000;
  localparam int ADDR_W = 12;
  localparam int WAIT_CYCLES = 2;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  data_mem_responder #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, push its expected response, return #1 after the
  // accepting edge.
  task automatic send(input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [31:0] wd, input logic [3:0] ws,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response, check latency, stall if asked, then compare
  // against the scoreboard and finish the handshake.
  task automatic recv(input string tag, input int stall);
    int   lat;
    exp_t e;
    logic [31:0] held;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      if (req_ready) check({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 2));
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, resp_rdata, e.rdata);
      check({tag, "_err"}, 32'(resp_err), 32'(e.err));
    end
    if (stall > 0) begin
      held = resp_rdata;
      resp_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        #1;
        check({tag, "_stall_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_stall_rdata"}, resp_rdata, held);
        check({tag, "_stall_req_ready"}, 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_valid_dropped"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = 32'd0;
    req_wstrb  = 4'd0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full-word store then load.
    send(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    recv("st_full", 0);
    send(1'b0, 12'h010, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);
    recv("ld_full", 0);

    // Single-lane store, then load with a 3-cycle response stall; a store
    // offered during the stall must be ignored.
    send(1'b1, 12'h010, 32'h000000AA, 4'b0001, 32'd0, 1'b0);
    recv("st_lane0", 0);
    send(1'b0, 12'h010, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);
    fork
      recv("ld_stall", 3);
      begin
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 12'h010;
        req_wdata = 32'hFFFFFFFF;
        req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
      end
    join
    send(1'b0, 12'h010, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);
    recv("ld_ignored_req", 0);

    // Middle-lane store and empty-strobe store.
    send(1'b1, 12'h010, 32'h55667788, 4'b0110, 32'd0, 1'b0);
    recv("st_lane12", 0);
    send(1'b1, 12'h010, 32'h11223344, 4'b1000, 32'd0, 1'b0);
    recv("st_lane3", 0);
    send(1'b1, 12'h010, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0);
    recv("st_nostrb", 0);
    send(1'b0, 12'h010, 32'd0, 4'h0, 32'h116677AA, 1'b0);
    recv("ld_lanes", 0);

    // Range boundary: last word valid, index DEPTH rejected.
    send(1'b1, 12'hF9C, 32'h99999999, 4'hF, 32'd0, 1'b0);
    recv("st_last", 0);
    send(1'b0, 12'hFA0, 32'd0, 4'h0, 32'd0, 1'b1);
    recv("ld_oob", 0);
    send(1'b1, 12'hFA0, 32'h12121212, 4'hF, 32'd0, 1'b1);
    recv("st_oob", 0);
    send(1'b0, 12'hF9C, 32'd0, 4'h0, 32'h99999999, 1'b0);
    recv("ld_last", 0);

    // Reset during BUSY drops the store.
    send(1'b1, 12'h020, 32'h0BADF00D, 4'hF, 32'd0, 1'b0);
    recv("st_prior", 0);
    send(1'b1, 12'h020, 32'h12345678, 4'hF, 32'd0, 1'b0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (WAIT_CYCLES + 3) @(posedge clk);
    #1;
    check("rst_busy_no_resp", 32'(resp_valid), 32'd0);
    send(1'b0, 12'h020, 32'd0, 4'h0, 32'h0BADF00D, 1'b0);
    recv("ld_after_rst", 0);

    // Misaligned load.
`ifdef MEM_MISALIGN_CHECK_EN
    send(1'b0, 12'h013, 32'd0, 4'h0, 32'd0, 1'b1);
`else
    send(1'b0, 12'h013, 32'd0, 4'h0, 32'h116677AA, 1'b0);
`endif
    recv("ld_misalign", 0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
